// File: rtl/madd_tile_sched.sv
// Tile-serial matrix adder. LANES-wide operand tiles stream from two SRAMs through one adder
// row into a 2-entry result FIFO, which drains to the result port under valid/ready.
module madd_tile_sched #(
  parameter int unsigned ROWS         = 128,
  parameter int unsigned DIMENTION    = 768,
  parameter int unsigned WIDTH_ADDEND = 8,
  parameter int unsigned LANES        = 64,
  parameter int unsigned SAT          = 0,
  localparam int unsigned BEATS       = ROWS * DIMENTION / LANES,
  localparam int unsigned ADDR_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned DW          = LANES * WIDTH_ADDEND
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data1,
  input  logic [DW-1:0]     rd_data2,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data
);
  localparam int unsigned W = WIDTH_ADDEND;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic [DW-1:0]     fifo_data_q [2];
  logic [DW-1:0]     fifo_data_d [2];
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [ADDR_W-1:0] fifo_addr_d [2];
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              push, pop, credit_ok, drain_empty;
  logic [2:0]        occupancy;
  logic [W:0]        lane_sum;
  logic [DW-1:0]     sum_tile;

  assign wr_valid = (cnt_q != 2'd0);
  assign wr_data  = fifo_data_q[rptr_q];
  assign wr_addr  = fifo_addr_q[rptr_q];
  assign rd_addr  = rd_cnt_q;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign pop      = wr_valid && wr_ready;
  assign push     = infl_q;

  // A slot freed by this cycle's pop counts as available, giving one beat per cycle.
  assign occupancy = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign credit_ok = (occupancy < 3'd2);
  assign rd_en     = (state_q == StRun) && credit_ok;

  // Empty after this cycle's pop with nothing left to land.
  assign drain_empty = !infl_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

  always_comb begin
    sum_tile = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = {rd_data1[k*W+W-1], rd_data1[k*W +: W]} +
                 {rd_data2[k*W+W-1], rd_data2[k*W +: W]};
      if ((SAT != 0) && (lane_sum[W] != lane_sum[W-1])) begin
        sum_tile[k*W +: W] = lane_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        sum_tile[k*W +: W] = lane_sum[W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    infl_d      = rd_en;
    infl_addr_d = rd_en ? rd_cnt_q : infl_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          rd_cnt_d = '0;
        end
      end
      StRun: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_empty) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d  = StIdle;
      rd_cnt_d = '0;
      infl_d   = 1'b0;
    end
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (push) begin
      fifo_data_d[wptr_q] = sum_tile;
      fifo_addr_d[wptr_q] = infl_addr_q;
      wptr_d              = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (clear) begin
      cnt_d  = 2'd0;
      wptr_d = 1'b0;
      rptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      fifo_data_q <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
